hycube_host_arbiter: RTL and testbench
======================================

# hycube_host_arbiter

Arbitrates the HyCUBE configuration/data memory access port and execution control between two host requesters: the SPI command path (host 0) and the on-chip debug/test loader (host 1). It sits between the requesters and the HyCUBE DA/DoA/rw/start_exec interface. It applies round-robin grants with a burst limit, routes read data back to the issuing host, and locks the port while a kernel executes.

## Interface
- `DATA_WIDTH`, 16: DA and read-data width.
- `MAX_BURST`, 16: accepted beats before a grant must yield to a waiting host.
- `RD_DEPTH`, 4: outstanding reads tracked (power of 2).
- `clkOut`  in  1  sole clock, rising edge.
- `reset_network`  in  1  asynchronous, active-high reset.
- `hN_req` (N=0,1)  in  1  host N requests the port.
- `hN_da`  in  DATA_WIDTH  host N address/data word.
- `hN_da_valid`  in  2  host N beat qualifier; nonzero means a beat is offered.
- `hN_doa`  in  1  host N data-or-address select.
- `hN_rw`  in  1  1 = write, 0 = read.
- `hN_start`  in  1  host N requests kernel start.
- `hN_grant`  out  1  host N owns the port (registered).
- `hN_ready`  out  1  beat/start accepted this cycle if offered.
- `hN_rdata`  out  DATA_WIDTH  read return.
- `hN_rdata_valid`  out  1  read return strobe.
- `DA_out`, `DA_valid_out[1:0]`, `DoA_out`, `rw_out`  out  to HyCUBE.
- `start_exec_out`  out  1  one-cycle kernel start pulse.
- `data_out`  in  DATA_WIDTH  HyCUBE read data.
- `data_out_valid`  in  1  HyCUBE read data strobe.
- `exec_end`  in  1  HyCUBE kernel finished.
- `busy`  out  1  high in EXEC.
- `err_rd_orphan`  out  1  sticky flag; read data arrived with no outstanding tag.

## Operation
- States: IDLE, GRANT0, GRANT1, EXEC. Reset state is IDLE. On reset, all outputs are 0, the round-robin pointer favours host 0, the burst counter is 0 and the tag FIFO is empty.
- **IDLE:**
  - One requester present: that host is granted.
  - Both present: the host not served last is granted.
- **GRANTn, release and handoff:**
  - `hn_ready = 1` while the tag FIFO is not full.
  - Host n drops req: go to GRANTm if the other host is requesting, else IDLE.
  - Burst counter reaches MAX_BURST and the other host is requesting: go to GRANTm and clear the counter.
  - Burst counter reaches MAX_BURST and the other host is idle: hold the grant and clear the counter.
- **GRANTn, accepted beat** (`hn_da_valid != 0 && hn_ready`):
  - Drive da/doa/rw to the HyCUBE outputs and `DA_valid_out = hn_da_valid`.
  - Increment the burst counter.
  - If it is a read, push tag n into the tag FIFO.
  - Otherwise `DA_valid_out = 0`. DA_out, DoA_out and rw_out still mux the granted host, or are 0 when no host is granted.
- **Start:** `hn_start` in GRANTn is accepted only when `hn_da_valid == 0` and the tag FIFO is empty. `hn_ready` is 1 in that cycle. Accepted start goes to EXEC with `start_exec_out = 1` for exactly the first EXEC cycle. The grant is dropped and `busy = 1`.
- **EXEC:**
  - No grants and no ready.
  - `exec_end` sampled high goes to IDLE, and the pointer then favours the host that did not start.
  - `exec_end` outside EXEC is ignored.
- **Read return:** `data_out_valid` pops the FIFO head. The next cycle, `hK_rdata = data_out` and `hK_rdata_valid = 1` for the popped tag K.
  - `data_out_valid` with the FIFO empty: data is dropped and `err_rd_orphan` is set. It clears only on reset.
- **Push and pop in the same cycle:** both take effect and the count is unchanged. Full is registered, so a push never hits a full FIFO.

## Timing
- Request to grant: req high at edge t gives grant at t+1.
- Beat is combinational to the HyCUBE outputs in its accept cycle. Zero added latency.
- Read return: 1 cycle after `data_out_valid`.
- Start accept at t: `start_exec_out` high during t+1 only.
- Earliest `exec_end` honoured: t+1, the first EXEC cycle. IDLE at t+2, grant at t+3 at the earliest.
- Handoff GRANT0 to GRANT1 is direct, with no IDLE bubble.
- Reset asserted mid-burst or mid-EXEC: immediate return to the reset state. Reads in flight are forgotten. Their later returns set `err_rd_orphan`.

## Structure
- Package `hycube_arb_pkg`:
  - state enum `arb_state_e`
  - `HOST_W = 1` tag type
  - DA_valid encoding constants
  - burst-counter width function `$clog2(MAX_BURST+1)`
- Sub-module `rd_tag_fifo`: RD_DEPTH x 1-bit synchronous FIFO with registered full/empty. The arbiter FSM, counter and output muxes stay in the top level.

## Test plan
- Host 0 only, 3 writes (da = 0x0010, 0x1234, 0x5678) -> grant at cycle 1, three DA_valid_out beats with identical words, rw_out = 1, no rdata.
- Both hosts request continuously, MAX_BURST = 4 -> grants alternate every 4 accepted beats with no bubble; host 0 first after reset.
- Host 1 issues 4 reads with no returns -> 5th read stalled (`h1_ready = 0`). One `data_out_valid` with `data_out = 0xBEEF` -> `h1_rdata = 0xBEEF`, `h1_rdata_valid` one cycle later, ready returns.
- Host 0 start with a read outstanding -> not accepted until the return. Then `start_exec_out` is a single pulse, busy stays high, host 1 req ignored until `exec_end`. IDLE follows, then host 1 is granted.
- `data_out_valid` with empty FIFO -> `err_rd_orphan = 1` and stays set.
- `reset_network` pulse mid-burst with reads outstanding -> all outputs 0 asynchronously, IDLE, FIFO empty.

Source files
------------

// File: rtl/hycube_arb_pkg.sv
// Shared types and constants for the HyCUBE host arbiter.
// No logic of its own.
// No flow control of its own.
package hycube_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    EXEC   = 2'd3
  } arb_state_e;

  localparam int HOST_W = 1;
  typedef logic [HOST_W-1:0] host_tag_t;

  localparam host_tag_t TAG_H0 = 1'b0;
  localparam host_tag_t TAG_H1 = 1'b1;

  // DA_valid encoding: any nonzero value qualifies a beat.
  localparam logic [1:0] DAV_NONE = 2'b00;

  // Burst counter must be able to hold MAX_BURST itself.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// Small FIFO of host tags for reads outstanding at HyCUBE.
// Pop data is the current head (zero latency); full/empty are registered.
// Push while full and pop while empty are ignored; the owner gates on full/empty.
module rd_tag_fifo
  import hycube_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  host_tag_t push_tag,
  input  logic      pop,
  output host_tag_t pop_tag,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  host_tag_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_tag = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; simultaneous push+pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Tag storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  // Pointers, count and the registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/hycube_host_arbiter.sv
// Round-robin, burst-limited arbiter of the HyCUBE DA/DoA/rw/start port between two hosts.
// Grant 1 cycle after req; beats pass through combinationally; read data returns 1 cycle after data_out_valid.
// hN_ready drops while the read-tag FIFO is full; EXEC locks both hosts out until exec_end.
module hycube_host_arbiter
  import hycube_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 16,
  parameter int RD_DEPTH   = 4
) (
  input  logic                  clkOut,
  input  logic                  reset_network,
  input  logic                  h0_req,
  input  logic [DATA_WIDTH-1:0] h0_da,
  input  logic [1:0]            h0_da_valid,
  input  logic                  h0_doa,
  input  logic                  h0_rw,
  input  logic                  h0_start,
  input  logic                  h1_req,
  input  logic [DATA_WIDTH-1:0] h1_da,
  input  logic [1:0]            h1_da_valid,
  input  logic                  h1_doa,
  input  logic                  h1_rw,
  input  logic                  h1_start,
  output logic                  h0_grant,
  output logic                  h0_ready,
  output logic [DATA_WIDTH-1:0] h0_rdata,
  output logic                  h0_rdata_valid,
  output logic                  h1_grant,
  output logic                  h1_ready,
  output logic [DATA_WIDTH-1:0] h1_rdata,
  output logic                  h1_rdata_valid,
  output logic [DATA_WIDTH-1:0] DA_out,
  output logic [1:0]            DA_valid_out,
  output logic                  DoA_out,
  output logic                  rw_out,
  output logic                  start_exec_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  data_out_valid,
  input  logic                  exec_end,
  output logic                  busy,
  output logic                  err_rd_orphan
);

  localparam int CNT_W = burst_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  arb_state_e            state;
  arb_state_e            state_next;
  arb_state_e            other_state;
  host_tag_t             last;
  host_tag_t             last_next;
  host_tag_t             gnt_host;
  host_tag_t             other_tag;
  host_tag_t             pop_tag;
  logic [CNT_W-1:0]      burst_cnt;
  logic [CNT_W-1:0]      burst_cnt_next;
  logic [CNT_W-1:0]      beats;
  logic                  start_pulse;
  logic                  start_pulse_next;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  granted;
  logic                  sel_req;
  logic                  oth_req;
  logic [DATA_WIDTH-1:0] sel_da;
  logic [1:0]            sel_dav;
  logic                  sel_doa;
  logic                  sel_rw;
  logic                  sel_start;
  logic                  beat_acc;
  logic                  start_acc;
  logic                  push_rd;
  logic                  rd_vld_q;
  host_tag_t             rd_tag_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  orphan_q;

  assign granted     = (state == GRANT0) || (state == GRANT1);
  assign gnt_host    = (state == GRANT1) ? TAG_H1 : TAG_H0;
  assign other_state = (state == GRANT1) ? GRANT0 : GRANT1;
  assign other_tag   = (state == GRANT1) ? TAG_H0 : TAG_H1;

  // Pick the granted host's request lines; oth_req is the host waiting behind it.
  always_comb begin
    sel_req   = h0_req;
    sel_da    = h0_da;
    sel_dav   = h0_da_valid;
    sel_doa   = h0_doa;
    sel_rw    = h0_rw;
    sel_start = h0_start;
    oth_req   = h1_req;
    if (state == GRANT1) begin
      sel_req   = h1_req;
      sel_da    = h1_da;
      sel_dav   = h1_da_valid;
      sel_doa   = h1_doa;
      sel_rw    = h1_rw;
      sel_start = h1_start;
      oth_req   = h0_req;
    end
  end

  // A start may only launch with no beat offered and no read still in flight.
  assign beat_acc  = granted && (sel_dav != DAV_NONE) && !fifo_full;
  assign start_acc = granted && sel_start && (sel_dav == DAV_NONE) && fifo_empty;
  assign push_rd   = beat_acc && !sel_rw;

  assign h0_grant       = (state == GRANT0);
  assign h1_grant       = (state == GRANT1);
  assign h0_ready       = h0_grant && !fifo_full;
  assign h1_ready       = h1_grant && !fifo_full;
  assign DA_out         = granted ? sel_da : '0;
  assign DoA_out        = granted && sel_doa;
  assign rw_out         = granted && sel_rw;
  assign DA_valid_out   = beat_acc ? sel_dav : DAV_NONE;
  assign start_exec_out = start_pulse;
  assign busy           = (state == EXEC);
  assign h0_rdata_valid = rd_vld_q && (rd_tag_q == TAG_H0);
  assign h1_rdata_valid = rd_vld_q && (rd_tag_q == TAG_H1);
  assign h0_rdata       = h0_rdata_valid ? rd_data_q : '0;
  assign h1_rdata       = h1_rdata_valid ? rd_data_q : '0;
  assign err_rd_orphan  = orphan_q;

  // Next state: round-robin entry from IDLE, release/burst handoff, start and exec completion.
  always_comb begin
    state_next       = state;
    last_next        = last;
    burst_cnt_next   = burst_cnt;
    start_pulse_next = 1'b0;
    beats            = burst_cnt + CNT_W'(beat_acc);
    case (state)
      IDLE: begin
        burst_cnt_next = '0;
        if (h0_req && h1_req) begin
          state_next = (last == TAG_H0) ? GRANT1 : GRANT0;
          last_next  = ~last;
        end else if (h0_req) begin
          state_next = GRANT0;
          last_next  = TAG_H0;
        end else if (h1_req) begin
          state_next = GRANT1;
          last_next  = TAG_H1;
        end
      end
      GRANT0, GRANT1: begin
        burst_cnt_next = beats;
        if (start_acc) begin
          state_next       = EXEC;
          start_pulse_next = 1'b1;
          burst_cnt_next   = '0;
        end else if (!sel_req) begin
          burst_cnt_next = '0;
          if (oth_req) begin
            state_next = other_state;
            last_next  = other_tag;
          end else begin
            state_next = IDLE;
          end
        end else if (beats == BURST_LIMIT) begin
          burst_cnt_next = '0;
          if (oth_req) begin
            state_next = other_state;
            last_next  = other_tag;
          end
        end
      end
      EXEC: begin
        if (exec_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, round-robin pointer (reset favours host 0), burst counter and start pulse.
  always_ff @(posedge clkOut or posedge reset_network) begin
    if (reset_network) begin
      state       <= IDLE;
      last        <= TAG_H1;
      burst_cnt   <= '0;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      last        <= last_next;
      burst_cnt   <= burst_cnt_next;
      start_pulse <= start_pulse_next;
    end
  end

  // Read return: route data to the tag at the FIFO head; returns with no tag latch the orphan flag.
  always_ff @(posedge clkOut or posedge reset_network) begin
    if (reset_network) begin
      rd_vld_q  <= 1'b0;
      rd_tag_q  <= TAG_H0;
      rd_data_q <= '0;
      orphan_q  <= 1'b0;
    end else begin
      rd_vld_q <= data_out_valid && !fifo_empty;
      rd_tag_q <= pop_tag;
      if (data_out_valid) rd_data_q <= data_out;
      if (data_out_valid && fifo_empty) orphan_q <= 1'b1;
    end
  end

  rd_tag_fifo #(
    .DEPTH (RD_DEPTH)
  ) u_rd_tag_fifo (
    .clk      (clkOut),
    .rst      (reset_network),
    .push     (push_rd),
    .push_tag (gnt_host),
    .pop      (data_out_valid),
    .pop_tag  (pop_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_hycube_host_arbiter.sv
// Directed bench for hycube_host_arbiter with a queue-based reference model.
// Model advances on each rising edge; outputs compared every falling edge.
// Literal checks inside the scenarios pin the model's behaviour.
module tb_hycube_host_arbiter;

  localparam int DW = 16;
  localparam int MB = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          h0_req = 1'b0, h1_req = 1'b0;
  logic [DW-1:0] h0_da = '0, h1_da = '0;
  logic [1:0]    h0_da_valid = '0, h1_da_valid = '0;
  logic          h0_doa = 1'b0, h1_doa = 1'b0;
  logic          h0_rw = 1'b0, h1_rw = 1'b0;
  logic          h0_start = 1'b0, h1_start = 1'b0;
  logic [DW-1:0] data_out = '0;
  logic          data_out_valid = 1'b0;
  logic          exec_end = 1'b0;

  logic          h0_grant, h0_ready, h0_rdata_valid;
  logic          h1_grant, h1_ready, h1_rdata_valid;
  logic [DW-1:0] h0_rdata, h1_rdata, DA_out;
  logic [1:0]    DA_valid_out;
  logic          DoA_out, rw_out, start_exec_out, busy, err_rd_orphan;

  always #5 clk = ~clk;

  hycube_host_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB), .RD_DEPTH(RD)) dut (
    .clkOut(clk), .reset_network(rst),
    .h0_req(h0_req), .h0_da(h0_da), .h0_da_valid(h0_da_valid), .h0_doa(h0_doa),
    .h0_rw(h0_rw), .h0_start(h0_start),
    .h1_req(h1_req), .h1_da(h1_da), .h1_da_valid(h1_da_valid), .h1_doa(h1_doa),
    .h1_rw(h1_rw), .h1_start(h1_start),
    .h0_grant(h0_grant), .h0_ready(h0_ready), .h0_rdata(h0_rdata), .h0_rdata_valid(h0_rdata_valid),
    .h1_grant(h1_grant), .h1_ready(h1_ready), .h1_rdata(h1_rdata), .h1_rdata_valid(h1_rdata_valid),
    .DA_out(DA_out), .DA_valid_out(DA_valid_out), .DoA_out(DoA_out), .rw_out(rw_out),
    .start_exec_out(start_exec_out), .data_out(data_out), .data_out_valid(data_out_valid),
    .exec_end(exec_end), .busy(busy), .err_rd_orphan(err_rd_orphan)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: owner -1 = nobody, 0/1 = host, 2 = executing kernel.
  int            m_owner = -1;
  int            m_last  = 1;
  int            m_cnt   = 0;
  int            m_q[$];
  bit            m_pulse = 0;
  bit            m_rv    = 0;
  int            m_rtag  = 0;
  logic [DW-1:0] m_rd    = '0;
  bit            m_err   = 0;

  function automatic logic req_of(input int i);   return (i == 1) ? h1_req : h0_req;           endfunction
  function automatic logic [1:0] dav_of(input int i); return (i == 1) ? h1_da_valid : h0_da_valid; endfunction
  function automatic logic [DW-1:0] da_of(input int i); return (i == 1) ? h1_da : h0_da;         endfunction
  function automatic logic doa_of(input int i);   return (i == 1) ? h1_doa : h0_doa;           endfunction
  function automatic logic rw_of(input int i);    return (i == 1) ? h1_rw : h0_rw;             endfunction
  function automatic logic start_of(input int i); return (i == 1) ? h1_start : h0_start;       endfunction

  task automatic model_step();
    int g;
    int qsz;
    int beats;
    bit acc;
    bit sacc;
    g    = m_owner;
    qsz  = m_q.size();
    acc  = 0;
    sacc = 0;
    if (g == 0 || g == 1) begin
      acc  = (dav_of(g) != 2'b00) && (qsz < RD);
      sacc = start_of(g) && (dav_of(g) == 2'b00) && (qsz == 0);
    end
    m_rv = 0;
    if (data_out_valid) begin
      if (qsz > 0) begin
        m_rtag = m_q.pop_front();
        m_rv   = 1;
        m_rd   = data_out;
      end else begin
        m_err = 1;
      end
    end
    if (acc && !rw_of(g)) m_q.push_back(g);
    m_pulse = 0;
    if (m_owner == -1) begin
      if (h0_req && h1_req) m_owner = 1 - m_last;
      else if (h0_req)      m_owner = 0;
      else if (h1_req)      m_owner = 1;
      if (m_owner != -1) m_last = m_owner;
      m_cnt = 0;
    end else if (m_owner == 2) begin
      if (exec_end) m_owner = -1;
    end else begin
      beats = m_cnt + (acc ? 1 : 0);
      if (sacc) begin
        m_owner = 2;
        m_pulse = 1;
        m_cnt   = 0;
      end else if (!req_of(g)) begin
        m_cnt   = 0;
        m_owner = req_of(1 - g) ? 1 - g : -1;
        if (m_owner != -1) m_last = m_owner;
      end else if (beats == MB) begin
        m_cnt = 0;
        if (req_of(1 - g)) begin
          m_owner = 1 - g;
          m_last  = m_owner;
        end
      end else begin
        m_cnt = beats;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = 1; m_cnt = 0; m_q.delete();
      m_pulse = 0; m_rv = 0; m_err = 0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin : cmp
    int  g;
    bit  gr;
    bit  acc;
    bit  nf;
    g   = m_owner;
    gr  = (g == 0 || g == 1);
    nf  = (m_q.size() < RD);
    acc = gr && (dav_of(g) != 2'b00) && nf;
    chk("h0_grant", 32'(h0_grant), 32'(m_owner == 0));
    chk("h1_grant", 32'(h1_grant), 32'(m_owner == 1));
    chk("h0_ready", 32'(h0_ready), 32'(m_owner == 0 && nf));
    chk("h1_ready", 32'(h1_ready), 32'(m_owner == 1 && nf));
    chk("DA_valid_out", 32'(DA_valid_out), 32'(acc ? dav_of(g) : 2'b00));
    chk("DA_out", 32'(DA_out), 32'(gr ? da_of(g) : '0));
    chk("DoA_out", 32'(DoA_out), 32'(gr && doa_of(g)));
    chk("rw_out", 32'(rw_out), 32'(gr && rw_of(g)));
    chk("start_exec_out", 32'(start_exec_out), 32'(m_pulse));
    chk("busy", 32'(busy), 32'(m_owner == 2));
    chk("h0_rdata_valid", 32'(h0_rdata_valid), 32'(m_rv && m_rtag == 0));
    chk("h1_rdata_valid", 32'(h1_rdata_valid), 32'(m_rv && m_rtag == 1));
    chk("h0_rdata", 32'(h0_rdata), 32'((m_rv && m_rtag == 0) ? m_rd : '0));
    chk("h1_rdata", 32'(h1_rdata), 32'((m_rv && m_rtag == 1) ? m_rd : '0));
    chk("err_rd_orphan", 32'(err_rd_orphan), 32'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    h0_req = 0; h1_req = 0; h0_da = '0; h1_da = '0; h0_da_valid = '0; h1_da_valid = '0;
    h0_doa = 0; h1_doa = 0; h0_rw = 0; h1_rw = 0; h0_start = 0; h1_start = 0;
    data_out = '0; data_out_valid = 0; exec_end = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  logic [DW-1:0] w1 [3] = '{16'h0010, 16'h1234, 16'h5678};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2 rst = 1;
    step(); step();
    neg();
    chk("rst_h0_grant", 32'(h0_grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dav", 32'(DA_valid_out), 32'd0);
    chk("rst_err", 32'(err_rd_orphan), 32'd0);
    step();
    rst = 0;

    // Host 0 alone: three writes, grant one cycle after req.
    h0_req = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      h0_da = w1[i]; h0_da_valid = 2'b01; h0_rw = 1; h0_doa = 1;
      neg();
      chk("s1_grant", 32'(h0_grant), 32'd1);
      chk("s1_da", 32'(DA_out), 32'(w1[i]));
      chk("s1_dav", 32'(DA_valid_out), 32'd1);
      chk("s1_rw", 32'(rw_out), 32'd1);
      step();
    end
    clear_inputs();
    step();

    // Both hosts stream writes: grants swap every MB beats, host 0 first after reset.
    do_reset();
    h0_req = 1; h1_req = 1; h0_rw = 1; h1_rw = 1;
    h0_da_valid = 2'b11; h1_da_valid = 2'b10;
    step();
    for (int k = 0; k < 12; k++) begin
      h0_da = 16'hA000 + 16'(k); h1_da = 16'hB000 + 16'(k);
      neg();
      chk("s2_g0", 32'(h0_grant), 32'(((k / 4) % 2) == 0));
      chk("s2_dav", 32'(DA_valid_out), (((k / 4) % 2) == 0) ? 32'd3 : 32'd2);
      step();
    end
    clear_inputs();
    step(); step();

    // Host 1: four reads fill the tag FIFO, fifth stalls until one return.
    h1_req = 1;
    step();
    h1_rw = 0; h1_da_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      h1_da = 16'h0100 + 16'(i);
      neg();
      chk("s3_rdy", 32'(h1_ready), 32'd1);
      step();
    end
    h1_da = 16'h0104;
    neg();
    chk("s3_stall", 32'(h1_ready), 32'd0);
    chk("s3_stall_dav", 32'(DA_valid_out), 32'd0);
    step();
    data_out = 16'hBEEF; data_out_valid = 1;
    neg();
    chk("s3_stall2", 32'(h1_ready), 32'd0);
    step();
    data_out_valid = 0;
    neg();
    chk("s3_rvalid", 32'(h1_rdata_valid), 32'd1);
    chk("s3_rdata", 32'(h1_rdata), 32'hBEEF);
    chk("s3_ready_back", 32'(h1_ready), 32'd1);
    chk("s3_fifth_dav", 32'(DA_valid_out), 32'd1);
    step();
    h1_da_valid = 0;
    for (int i = 0; i < 4; i++) begin
      data_out = 16'hC000 + 16'(i); data_out_valid = 1;
      step();
    end
    clear_inputs();
    step(); step();

    // Host 0 start held off by an outstanding read, then EXEC locks the port.
    h0_req = 1;
    step();
    h0_rw = 0; h0_da_valid = 2'b01; h0_da = 16'h0200;
    step();
    h0_da_valid = 0; h0_start = 1; h1_req = 1;
    neg();
    chk("s4_busy_a", 32'(busy), 32'd0);
    step();
    data_out = 16'h00AA; data_out_valid = 1;
    neg();
    chk("s4_g0_b", 32'(h0_grant), 32'd1);
    chk("s4_busy_b", 32'(busy), 32'd0);
    step();
    data_out_valid = 0;
    neg();
    chk("s4_rvalid", 32'(h0_rdata_valid), 32'd1);
    chk("s4_rdata", 32'(h0_rdata), 32'h00AA);
    chk("s4_ready_c", 32'(h0_ready), 32'd1);
    step();
    h0_start = 0; h0_req = 0;
    neg();
    chk("s4_pulse", 32'(start_exec_out), 32'd1);
    chk("s4_busy_d", 32'(busy), 32'd1);
    chk("s4_g1_d", 32'(h1_grant), 32'd0);
    chk("s4_r1_d", 32'(h1_ready), 32'd0);
    step();
    neg();
    chk("s4_pulse_off", 32'(start_exec_out), 32'd0);
    chk("s4_busy_e", 32'(busy), 32'd1);
    chk("s4_g1_e", 32'(h1_grant), 32'd0);
    step();
    exec_end = 1;
    neg();
    chk("s4_busy_f", 32'(busy), 32'd1);
    step();
    exec_end = 0; h0_req = 1;
    neg();
    chk("s4_idle_busy", 32'(busy), 32'd0);
    chk("s4_idle_g0", 32'(h0_grant), 32'd0);
    chk("s4_idle_g1", 32'(h1_grant), 32'd0);
    step();
    neg();
    chk("s4_g1_after", 32'(h1_grant), 32'd1);
    chk("s4_g0_after", 32'(h0_grant), 32'd0);
    step();
    clear_inputs();
    step(); step();

    // Read data with nothing outstanding latches the sticky orphan flag.
    data_out = 16'hDEAD; data_out_valid = 1;
    neg();
    chk("s5_err_pre", 32'(err_rd_orphan), 32'd0);
    step();
    data_out_valid = 0;
    neg();
    chk("s5_err", 32'(err_rd_orphan), 32'd1);
    chk("s5_no_rv0", 32'(h0_rdata_valid), 32'd0);
    chk("s5_no_rv1", 32'(h1_rdata_valid), 32'd0);
    step(); step();
    neg();
    chk("s5_err_sticky", 32'(err_rd_orphan), 32'd1);
    step();

    // Asynchronous reset mid-burst with reads outstanding.
    h0_req = 1;
    step();
    h0_rw = 0; h0_da_valid = 2'b01; h0_da = 16'h0300;
    step(); step();
    #2 rst = 1;
    #1;
    chk("s6_g0", 32'(h0_grant), 32'd0);
    chk("s6_rdy", 32'(h0_ready), 32'd0);
    chk("s6_dav", 32'(DA_valid_out), 32'd0);
    chk("s6_da", 32'(DA_out), 32'd0);
    chk("s6_err", 32'(err_rd_orphan), 32'd0);
    clear_inputs();
    step();
    rst = 0;
    data_out = 16'h1234; data_out_valid = 1;
    step();
    data_out_valid = 0;
    neg();
    chk("s6_orphan", 32'(err_rd_orphan), 32'd1);
    chk("s6_no_rv", 32'(h0_rdata_valid), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
